// File: rtl/mult_div_pkg.sv
// Shared definitions for the multiply/divide sequencer: FSM states,
// op encodings and step-counter sizing.
package mult_div_pkg;

  localparam int N_STEPS_DEFAULT = 32;
  localparam int STEP_W          = 6;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    WRITE = 3'd3,
    DZ    = 3'd4
  } md_state_t;

endpackage

// File: rtl/md_step_counter.sv
// Iteration counter for the mult/div sequencer. Clear has priority over
// enable; the count saturates at the terminal value so it never wraps.
module md_step_counter
  import mult_div_pkg::*;
#(
  parameter int N_STEPS = N_STEPS_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              enable,
  output logic [STEP_W-1:0] count,
  output logic              tc
);

  // Terminal count marks the last iteration of an operation.
  assign tc = (count == STEP_W'(N_STEPS - 1));

  // Count iterations; hold at terminal count until the next clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !tc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mult_div_ctrl.sv
// Multiply/divide sequencer for the multi-cycle MIPS core.
// Takes a MULT/DIV request, walks the datapath through load, N_STEPS
// iterations and a HI/LO commit, stalls MFHI/MFLO while busy and flags
// divide-by-zero instead of committing.
// Optional build macro MD_ABORT_EN adds an 'abort' input that flushes an
// operation in LOAD or RUN without committing.
//
// Handshake: start is a single-cycle request honoured only in IDLE; a start
// in any other state is dropped (not queued). done and div_zero are
// single-cycle completion pulses; stall = hilo_read & busy.
module mult_div_ctrl
  import mult_div_pkg::*;
#(
  parameter int N_STEPS = N_STEPS_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              op,
  input  logic [31:0]       divisor_in,
  input  logic              hilo_read,
`ifdef MD_ABORT_EN
  input  logic              abort,
`endif
  output logic              md_load,
  output logic              md_step,
  output logic              md_control,
  output logic [STEP_W-1:0] step_idx,
  output logic              hilo_wr,
  output logic              busy,
  output logic              stall,
  output logic              done,
  output logic              div_zero,
  output logic [2:0]        state_dbg
);

  md_state_t         state;
  logic [STEP_W-1:0] count;
  logic              tc;
  logic              abort_req;

`ifdef MD_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Counter is cleared while loading and advances only while iterating.
  md_step_counter #(
    .N_STEPS (N_STEPS)
  ) u_counter (
    .clock  (clock),
    .reset  (reset),
    .clear  (state == LOAD),
    .enable (state == RUN),
    .count  (count),
    .tc     (tc)
  );

  // Index is only meaningful while stepping; otherwise held at zero.
  assign step_idx  = md_step ? count : '0;
  assign stall     = hilo_read & busy;
  assign state_dbg = state;

  // Sequencer FSM with registered strobes computed alongside the next state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      md_control <= OP_MULT;
      md_load    <= 1'b0;
      md_step    <= 1'b0;
      hilo_wr    <= 1'b0;
      done       <= 1'b0;
      div_zero   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      md_load  <= 1'b0;
      md_step  <= 1'b0;
      hilo_wr  <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            md_control <= op;
            if (op == OP_DIV && divisor_in == '0) begin
              state    <= DZ;
              div_zero <= 1'b1;
            end else begin
              state   <= LOAD;
              md_load <= 1'b1;
              busy    <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (abort_req) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state   <= RUN;
            md_step <= 1'b1;
          end
        end
        RUN: begin
          if (abort_req) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (tc) begin
            state   <= WRITE;
            hilo_wr <= 1'b1;
            done    <= 1'b1;
          end else begin
            md_step <= 1'b1;
          end
        end
        WRITE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        DZ: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Bench for mult_div_ctrl: directed timing checks plus random traffic
// compared every cycle against a timeline model (cycles since accept).
module tb_mult_div_ctrl;

  localparam int N = 32;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] divisor_in = '0;
  logic        hilo_read = 1'b0;
  logic        abort = 1'b0;

  logic        md_load, md_step, md_control, hilo_wr, busy, stall, done, div_zero;
  logic [5:0]  step_idx;
  logic [2:0]  state_dbg;

  mult_div_ctrl #(.N_STEPS(N)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .divisor_in (divisor_in),
    .hilo_read  (hilo_read),
`ifdef MD_ABORT_EN
    .abort      (abort),
`endif
    .md_load    (md_load),
    .md_step    (md_step),
    .md_control (md_control),
    .step_idx   (step_idx),
    .hilo_wr    (hilo_wr),
    .busy       (busy),
    .stall      (stall),
    .done       (done),
    .div_zero   (div_zero),
    .state_dbg  (state_dbg)
  );

  // clock / reset block
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_wr     = 0;

  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Behavioural model: an accepted op is a timeline t = 1..N+2 after the
  // start cycle; a divide-by-zero is a single pulse cycle.
  bit          m_active = 0;
  bit          m_dz = 0;
  bit          m_ctl = 0;
  int          m_t = 0;
  bit          was_idle;
  logic [31:0] exp_q[$];

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_active = 0;
      m_dz     = 0;
      m_ctl    = 0;
      m_t      = 0;
      exp_q.delete();
    end else begin
      was_idle = !m_active && !m_dz;
      m_dz = 0;
      if (m_active) begin
        if (abort && m_t <= N + 1) begin
          m_active = 0;
          if (exp_q.size() != 0) void'(exp_q.pop_back());
        end else if (m_t == N + 2) begin
          m_active = 0;
          check("commit_missing", exp_q.size(), 0);
          exp_q.delete();
        end else begin
          m_t++;
        end
      end
      if (was_idle && start) begin
        m_ctl = op;
        if (op && divisor_in == 0) begin
          m_dz = 1;
        end else begin
          m_active = 1;
          m_t = 1;
          exp_q.push_back({31'd0, op});
        end
      end
    end
  end

  // Scoreboard / compare process: every output, every cycle.
  always @(negedge clock) begin
    bit exp_step;
    bit exp_wr;
    exp_step = m_active && m_t >= 2 && m_t <= N + 1;
    exp_wr   = m_active && m_t == N + 2;
    check("busy", busy, m_active);
    check("md_load", md_load, m_active && m_t == 1);
    check("md_step", md_step, exp_step);
    check("step_idx", step_idx, exp_step ? m_t - 2 : 0);
    check("hilo_wr", hilo_wr, exp_wr);
    check("done", done, exp_wr);
    check("div_zero", div_zero, m_dz);
    check("md_control", md_control, m_ctl);
    check("stall", stall, hilo_read && m_active);
    if (hilo_wr) begin
      n_wr++;
      if (exp_q.size() == 0) check("commit_unexpected", 1, 0);
      else check("commit_op", md_control, exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic go_to(input int from_c, input int to_c);
    for (int c = from_c; c < to_c; c++) tick();
  endtask

  // Issue a one-cycle start; returns in cycle 1 of the operation.
  task automatic issue(input logic o, input logic [31:0] d);
    tick();
    start = 1'b1;
    op = o;
    divisor_in = d;
    tick();
    start = 1'b0;
  endtask

  task automatic run_mult_timed();
    issue(1'b0, 32'd3);
    @(negedge clock);
    check("t_load_c1", md_load, 1);
    check("t_busy_c1", busy, 1);
    for (int c = 2; c <= 33; c++) begin
      tick();
      @(negedge clock);
      check("t_step", md_step, 1);
      check("t_idx", step_idx, c - 2);
    end
    tick();
    @(negedge clock);
    check("t_wr_c34", hilo_wr, 1);
    check("t_done_c34", done, 1);
    check("t_step_c34", md_step, 0);
    tick();
    @(negedge clock);
    check("t_busy_c35", busy, 0);
    check("t_wr_c35", hilo_wr, 0);
  endtask

  initial begin
    int wr0;
    // reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_outs", {md_load, md_step, md_control, hilo_wr, stall, done, div_zero}, 0);
    check("rst_idx", step_idx, 0);
    tick();
    reset = 1'b1;

    // MULT latency
    run_mult_timed();

    // DIV by zero
    issue(1'b1, 32'd0);
    @(negedge clock);
    check("dz_pulse", div_zero, 1);
    check("dz_busy", busy, 0);
    check("dz_ctl", md_control, 1);
    check("dz_load", md_load, 0);
    tick();
    @(negedge clock);
    check("dz_pulse_end", div_zero, 0);
    check("dz_step", md_step, 0);

    // DIV by 7 with a held read
    issue(1'b1, 32'd7);
    go_to(1, 9);
    tick();
    hilo_read = 1'b1;
    @(negedge clock);
    check("stall_c10", stall, 1);
    go_to(10, 34);
    @(negedge clock);
    check("stall_c34", stall, 1);
    check("div_wr_c34", hilo_wr, 1);
    tick();
    @(negedge clock);
    check("stall_c35", stall, 0);
    hilo_read = 1'b0;

    // second start during a MULT is dropped
    wr0 = n_wr;
    issue(1'b0, 32'd1);
    go_to(1, 4);
    tick();
    start = 1'b1;
    op = 1'b1;
    divisor_in = 32'd0;
    tick();
    start = 1'b0;
    go_to(6, 34);
    @(negedge clock);
    check("ign_wr_c34", hilo_wr, 1);
    check("ign_ctl", md_control, 0);
    go_to(34, 37);
    check("ign_one_wr", n_wr - wr0, 1);

    // asynchronous reset mid-DIV
    issue(1'b1, 32'd5);
    go_to(1, 20);
    #2 reset = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_outs", {md_load, md_step, md_control, hilo_wr, done}, 0);
    check("arst_idx", step_idx, 0);
    wr0 = n_wr;
    tick();
    reset = 1'b1;
    go_to(0, 20);
    check("arst_no_wr", n_wr - wr0, 0);
    run_mult_timed();

`ifdef MD_ABORT_EN
    wr0 = n_wr;
    issue(1'b0, 32'd9);
    go_to(1, 15);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clock);
    check("abort_c16_busy", busy, 0);
    go_to(16, 36);
    check("abort_no_wr", n_wr - wr0, 0);
    issue(1'b1, 32'd9);
    go_to(1, 34);
    abort = 1'b1;
    @(negedge clock);
    check("abort_write_wr", hilo_wr, 1);
    tick();
    abort = 1'b0;
`endif

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      tick();
      start      = ($urandom_range(0, 9) == 0);
      op         = 1'($urandom_range(0, 1));
      divisor_in = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      hilo_read  = ($urandom_range(0, 3) == 0);
`ifdef MD_ABORT_EN
      abort      = ($urandom_range(0, 59) == 0);
`endif
      if ($urandom_range(0, 1499) == 0) begin
        #2 reset = 1'b0;
        tick();
        reset = 1'b1;
      end
    end
    tick();
    start = 1'b0;
    hilo_read = 1'b0;
    abort = 1'b0;
    go_to(0, 40);
    check("drain_queue", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_div_ctrl.md
Name: mult_div_ctrl

Overview:
Sequencer for the multiply/divide datapath in the multi-cycle MIPS core. It accepts a MULT/DIV request from the main control unit and drives the datapath's load/step/op signals through a fixed iteration count. It then commits the result to HI/LO and stalls MFHI/MFLO reads while an operation is in flight. It detects divide-by-zero and raises an exception pulse instead of writing HI/LO.

Parameters:
N_STEPS, 32, iterations per operation (one per operand bit); step counter width is 6 bits and fixed.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle request from control unit; sampled only in IDLE
op  in  1  0 = MULT, 1 = DIV; sampled with start
divisor_in  in  32  regB value; checked for zero with start when op=1
hilo_read  in  1  control unit is executing MFHI/MFLO this cycle
md_load  out  1  datapath loads operands and clears partial results
md_step  out  1  datapath performs one Booth or restoring-divide iteration
md_control  out  1  latched op, held stable for the whole operation
step_idx  out  6  current iteration index, 0..N_STEPS-1
hilo_wr  out  1  write enable for HI and LO
busy  out  1  operation in flight
stall  out  1  freeze the control unit
done  out  1  one-cycle completion pulse
div_zero  out  1  one-cycle divide-by-zero exception pulse

Behaviour:
- Reset (reset=0, async): state=IDLE, counter=0, op latch=0. All outputs are 0.
- States: IDLE, LOAD, RUN, WRITE, DZ.
- IDLE:
  - start=1 and op=1 and divisor_in=0 -> DZ.
  - start=1 otherwise -> LOAD; latch op into md_control.
  - start=0 -> stay in IDLE.
- LOAD: one cycle, md_load=1, counter cleared -> RUN.
- RUN: md_step=1 and step_idx=counter every cycle. Counter increments each cycle. On counter=N_STEPS-1 -> WRITE; the counter does not wrap past this.
- WRITE: one cycle, hilo_wr=1 and done=1 -> IDLE.
- DZ: one cycle, div_zero=1, no md_load, md_step or hilo_wr -> IDLE. HI/LO keep their previous values.
- busy=1 in LOAD, RUN and WRITE; busy=0 in IDLE and DZ.
- stall = hilo_read & busy. A read coincident with WRITE also stalls, so it sees the new value on the following cycle.
- Latency: start at cycle 0 -> md_load at cycle 1 -> md_step at cycles 2..N_STEPS+1 -> hilo_wr and done at cycle N_STEPS+2 (34 for the default). The next start is accepted in the cycle after WRITE.
- start while not in IDLE is ignored and not queued; op and divisor_in are ignored at that time.
- start and hilo_read in the same IDLE cycle: no stall, because the read sees the old HI/LO.
- md_control changes only on an accepted start. In DZ, md_control still latches op=1.
- Reset mid-operation: immediate return to IDLE with all outputs 0. No hilo_wr is issued.
- All outputs are registered or decoded from the state register only. There is no combinational path from start to the md_* outputs.

Optional Feature:
MD_ABORT_EN
- Defined: adds input port abort (1 bit, pipeline flush). abort=1 in LOAD or RUN -> IDLE on the next edge with no hilo_wr and no done. abort in WRITE is ignored because the commit completes. abort in IDLE or DZ has no effect.
- Undefined: no abort port exists; an operation always runs to WRITE or DZ.

Decomposition:
- Package mult_div_pkg holds:
  - state enum: IDLE, LOAD, RUN, WRITE, DZ
  - OP_MULT=1'b0 and OP_DIV=1'b1
  - N_STEPS_DEFAULT=32 and STEP_W=6
- One sub-module, md_step_counter: 6-bit counter with clear, enable and terminal-count output (count==N_STEPS-1). It is instantiated once by the FSM.

Test Plan:
- Reset, then MULT: start=1, op=0, one pulse -> md_load at cycle 1. md_step high at cycles 2..33 with step_idx 0..31. hilo_wr=done=1 only at cycle 34; busy low at cycle 35.
- DIV by zero: start=1, op=1, divisor_in=0 -> div_zero=1 at cycle 1 only. md_load, md_step and hilo_wr stay 0 throughout; busy stays 0.
- DIV with divisor_in=7, then hilo_read=1 held from cycle 10 -> stall=1 for cycles 10..34. stall=0 at cycle 35.
- Second start pulse at cycle 5 of an active MULT -> ignored. Exactly one hilo_wr at cycle 34; md_control unchanged.
- Assert reset=0 asynchronously at cycle 20 of a DIV -> outputs 0 immediately. After release, no hilo_wr occurs and a fresh start gives normal 34-cycle timing.
- With MD_ABORT_EN defined: abort at cycle 15 -> IDLE at cycle 16 with no hilo_wr or done. With abort at cycle 34 (WRITE), hilo_wr still fires.
